// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice state out.
// Events are scanned one voice per cycle, then committed in one edge.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int TICK_WIDTH = 24,
   parameter int AGE_WIDTH  = 8
) (
   input  logic                             CLOCK_50,
   input  logic                             RESET_N,
   input  logic                             EVT_VALID,
   output logic                             EVT_READY,
   input  logic                             EVT_NOTE_ON,
   input  logic [6:0]                       EVT_NOTE,
   input  logic [TICK_WIDTH-1:0]            EVT_TICKS,
   output logic [NUM_VOICES-1:0]            VOICE_ACTIVE,
   output logic [NUM_VOICES*7-1:0]          VOICE_NOTE,
   output logic [NUM_VOICES*TICK_WIDTH-1:0] VOICE_TICKS,
   output logic                             STEAL_PULSE,
   output logic [7:0]                       LED
);

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
   localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t                  state;
   logic [IW-1:0]           idx;
   logic                    ready_q;
   logic                    lat_on;
   logic [6:0]              lat_note;
   logic [TICK_WIDTH-1:0]   lat_ticks;
   logic                    m_hit, f_hit, o_hit;
   logic [IW-1:0]           m_idx, f_idx, o_idx;
   logic [AGE_WIDTH-1:0]    o_age;

   logic [NUM_VOICES-1:0]   active_q;
   logic [6:0]              note_q  [NUM_VOICES];
   logic [TICK_WIDTH-1:0]   ticks_q [NUM_VOICES];
   logic [AGE_WIDTH-1:0]    age_q   [NUM_VOICES];
   logic                    steal_q;
   logic [7:0]              led_q;

   logic                    is_on;
   logic                    steal;
   logic [IW-1:0]           tgt;
   logic [NUM_VOICES-1:0]   nxt_active;
   logic [6:0]              nxt_note  [NUM_VOICES];
   logic [TICK_WIDTH-1:0]   nxt_ticks [NUM_VOICES];
   logic [AGE_WIDTH-1:0]    nxt_age   [NUM_VOICES];
   logic [7:0]              led_nxt;

   // Handshake FSM plus the one-voice-per-cycle search.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         idx       <= '0;
         lat_on    <= 1'b0;
         lat_note  <= '0;
         lat_ticks <= '0;
         m_hit     <= 1'b0;
         f_hit     <= 1'b0;
         o_hit     <= 1'b0;
         m_idx     <= '0;
         f_idx     <= '0;
         o_idx     <= '0;
         o_age     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (EVT_VALID) begin
                  lat_on    <= EVT_NOTE_ON;
                  lat_note  <= EVT_NOTE;
                  lat_ticks <= EVT_TICKS;
                  idx       <= '0;
                  m_hit     <= 1'b0;
                  f_hit     <= 1'b0;
                  o_hit     <= 1'b0;
                  m_idx     <= '0;
                  f_idx     <= '0;
                  o_idx     <= '0;
                  o_age     <= '0;
                  ready_q   <= 1'b0;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (active_q[idx]) begin
                  if (!m_hit && note_q[idx] == lat_note) begin
                     m_hit <= 1'b1;
                     m_idx <= idx;
                  end
                  if (!o_hit || age_q[idx] > o_age) begin
                     o_hit <= 1'b1;
                     o_idx <= idx;
                     o_age <= age_q[idx];
                  end
               end else if (!f_hit) begin
                  f_hit <= 1'b1;
                  f_idx <= idx;
               end
               if (idx == LAST) state <= COMMIT;
               else idx <= idx + 1'b1;
            end
            COMMIT: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Next voice table from the search results; ticks of 0 means release.
   always_comb begin
      is_on      = lat_on && (lat_ticks != '0);
      steal      = is_on && !m_hit && !f_hit;
      tgt        = m_hit ? m_idx : (f_hit ? f_idx : o_idx);
      nxt_active = active_q;
      for (int i = 0; i < NUM_VOICES; i++) begin
         nxt_note[i]  = note_q[i];
         nxt_ticks[i] = ticks_q[i];
         nxt_age[i]   = age_q[i];
         if (is_on) begin
            if (IW'(i) == tgt) begin
               nxt_active[i] = 1'b1;
               nxt_note[i]   = lat_note;
               nxt_ticks[i]  = lat_ticks;
               nxt_age[i]    = '0;
            end else if (active_q[i] && age_q[i] != AGE_MAX) begin
               nxt_age[i] = age_q[i] + 1'b1;
            end
         end else if (m_hit && IW'(i) == m_idx) begin
            nxt_active[i] = 1'b0;
            nxt_note[i]   = '0;
            nxt_ticks[i]  = '0;
            nxt_age[i]    = '0;
         end
      end
   end

   for (genvar j = 0; j < 8; j++) begin : g_led
      if (j < NUM_VOICES) begin : g_on
         assign led_nxt[j] = nxt_active[j];
      end else begin : g_off
         assign led_nxt[j] = 1'b0;
      end
   end

   // Voice table and all status outputs move only on the commit edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         active_q <= '0;
         steal_q  <= 1'b0;
         led_q    <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i]  <= '0;
            ticks_q[i] <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         steal_q <= 1'b0;
         if (state == COMMIT) begin
            active_q <= nxt_active;
            steal_q  <= steal;
            led_q    <= led_nxt;
            for (int i = 0; i < NUM_VOICES; i++) begin
               note_q[i]  <= nxt_note[i];
               ticks_q[i] <= nxt_ticks[i];
               age_q[i]   <= nxt_age[i];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
      assign VOICE_NOTE[7*g +: 7]                   = note_q[g];
      assign VOICE_TICKS[TICK_WIDTH*g +: TICK_WIDTH] = ticks_q[g];
   end

   assign EVT_READY    = ready_q;
   assign VOICE_ACTIVE = active_q;
   assign STEAL_PULSE  = steal_q;
   assign LED          = led_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (4 voices, 24-bit ticks).
// A behavioural voice model predicts each commit; results are queued.
module tb_voice_allocator;

   localparam int N  = 4;
   localparam int TW = 24;

   logic          clk;
   logic          rst_n;
   logic          evt_valid;
   logic          evt_ready;
   logic          evt_note_on;
   logic [6:0]    evt_note;
   logic [TW-1:0] evt_ticks;
   logic [N-1:0]  voice_active;
   logic [N*7-1:0]  voice_note;
   logic [N*TW-1:0] voice_ticks;
   logic          steal_pulse;
   logic [7:0]    led;

   voice_allocator #(.NUM_VOICES(N), .TICK_WIDTH(TW), .AGE_WIDTH(8)) dut (
      .CLOCK_50     (clk),
      .RESET_N      (rst_n),
      .EVT_VALID    (evt_valid),
      .EVT_READY    (evt_ready),
      .EVT_NOTE_ON  (evt_note_on),
      .EVT_NOTE     (evt_note),
      .EVT_TICKS    (evt_ticks),
      .VOICE_ACTIVE (voice_active),
      .VOICE_NOTE   (voice_note),
      .VOICE_TICKS  (voice_ticks),
      .STEAL_PULSE  (steal_pulse),
      .LED          (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]    act;
      logic [N*7-1:0]  note;
      logic [N*TW-1:0] ticks;
      logic [7:0]      led;
      logic            steal;
   } exp_t;

   exp_t sb[$];
   int passed = 0;
   int total  = 0;

   bit            m_act   [N];
   logic [6:0]    m_note  [N];
   logic [TW-1:0] m_ticks [N];
   int            m_age   [N];

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_note[i] = '0; m_ticks[i] = '0; m_age[i] = 0;
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      e = '0;
      for (int i = 0; i < N; i++) begin
         e.act[i]            = m_act[i];
         e.note[7*i +: 7]    = m_note[i];
         e.ticks[TW*i +: TW] = m_ticks[i];
         if (i < 8) e.led[i] = m_act[i];
      end
      return e;
   endfunction

   task automatic model_apply(input bit on, input logic [6:0] n,
                              input logic [TW-1:0] t, output bit stl);
      int hit, fr, old, tg;
      hit = -1; fr = -1; old = -1; stl = 0;
      for (int i = 0; i < N; i++) begin
         if (m_act[i] && m_note[i] == n && hit < 0) hit = i;
         if (!m_act[i] && fr < 0) fr = i;
         if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
      end
      if (on && t != 0) begin
         if (hit >= 0) tg = hit;
         else if (fr >= 0) tg = fr;
         else begin tg = old; stl = 1; end
         for (int i = 0; i < N; i++)
            if (i != tg && m_act[i] && m_age[i] < 255) m_age[i]++;
         m_act[tg] = 1; m_note[tg] = n; m_ticks[tg] = t; m_age[tg] = 0;
      end else if (hit >= 0) begin
         m_act[hit] = 0; m_note[hit] = '0; m_ticks[hit] = '0; m_age[hit] = 0;
      end
   endtask

   task automatic send(input bit on, input logic [6:0] n,
                       input logic [TW-1:0] t);
      exp_t prev, e;
      bit stl;
      int guard;
      prev = snap();
      model_apply(on, n, t, stl);
      e = snap();
      e.steal = stl;
      sb.push_back(e);
      @(negedge clk);
      evt_valid = 1; evt_note_on = on; evt_note = n; evt_ticks = t;
      guard = 0;
      while (!evt_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 50) $display("FAIL ready_timeout: got %b want 1", evt_ready);
      else passed++;
      @(posedge clk); #1;
      evt_valid = 0;
      total++;
      if (evt_ready !== 1'b0)
         $display("FAIL ready_drop n=%0d: got %b want 0", n, evt_ready);
      else passed++;
      repeat (N) @(posedge clk);
      #1;
      total++;
      if (evt_ready !== 1'b0 || voice_active !== prev.act ||
          voice_note !== prev.note || voice_ticks !== prev.ticks ||
          led !== prev.led || steal_pulse !== 1'b0)
         $display("FAIL early_change n=%0d: got rdy=%b act=%b want rdy=0 act=%b",
                  n, evt_ready, voice_active, prev.act);
      else passed++;
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (evt_ready !== 1'b1)
         $display("FAIL ready_back n=%0d: got %b want 1", n, evt_ready);
      else passed++;
      total++;
      if (voice_active !== e.act || led !== e.led)
         $display("FAIL active n=%0d: got %b/%h want %b/%h",
                  n, voice_active, led, e.act, e.led);
      else passed++;
      total++;
      if (voice_note !== e.note || voice_ticks !== e.ticks)
         $display("FAIL voices n=%0d: got %h/%h want %h/%h",
                  n, voice_note, voice_ticks, e.note, e.ticks);
      else passed++;
      total++;
      if (steal_pulse !== e.steal)
         $display("FAIL steal n=%0d: got %b want %b", n, steal_pulse, e.steal);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (steal_pulse !== 1'b0)
         $display("FAIL steal_clear n=%0d: got %b want 0", n, steal_pulse);
      else passed++;
   endtask

   task automatic check_cleared(input string tag);
      total++;
      if (evt_ready !== 1'b1 || voice_active !== '0 || voice_note !== '0 ||
          voice_ticks !== '0 || led !== 8'h00 || steal_pulse !== 1'b0)
         $display("FAIL %s: got rdy=%b act=%b led=%h stl=%b want 1/0/00/0",
                  tag, evt_ready, voice_active, led, steal_pulse);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 0; evt_valid = 0; evt_note_on = 0; evt_note = '0; evt_ticks = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset_held");
      @(negedge clk);
      rst_n = 1;
      #1;
      check_cleared("reset_release");
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         logic [6:0] nt [4];
         nt[0] = 7'd60; nt[1] = 7'd62; nt[2] = 7'd64; nt[3] = 7'd65;
         send(1, nt[i], 24'(1000 + i));
      end
      total++;
      if (voice_active !== 4'b1111 || led !== 8'h0F)
         $display("FAIL fill_full: got %b/%h want 1111/0f", voice_active, led);
      else passed++;
   endtask

   task automatic test_steal();
      send(1, 7'd67, 24'd2000);
      total++;
      if (voice_note[6:0] !== 7'd67 || voice_ticks[TW-1:0] !== 24'd2000)
         $display("FAIL steal_v0: got %0d/%0d want 67/2000",
                  voice_note[6:0], voice_ticks[TW-1:0]);
      else passed++;
   endtask

   task automatic test_note_off();
      send(0, 7'd62, 24'd0);
      total++;
      if (led !== 8'h0D)
         $display("FAIL off_led: got %h want 0d", led);
      else passed++;
      send(1, 7'd69, 24'd1500);
      total++;
      if (voice_note[13:7] !== 7'd69)
         $display("FAIL reuse_v1: got %0d want 69", voice_note[13:7]);
      else passed++;
   endtask

   task automatic test_retrigger();
      send(1, 7'd64, 24'd3000);
      total++;
      if (voice_ticks[2*TW +: TW] !== 24'd3000)
         $display("FAIL retrig_v2: got %0d want 3000", voice_ticks[2*TW +: TW]);
      else passed++;
      send(0, 7'd50, 24'd0);
      send(1, 7'd65, 24'd0);
      total++;
      if (voice_active[3] !== 1'b0)
         $display("FAIL zero_tick_release: got %b want 0", voice_active[3]);
      else passed++;
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      evt_valid = 1; evt_note_on = 1; evt_note = 7'd71; evt_ticks = 24'd5;
      @(posedge clk); #1;
      evt_valid = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check_cleared("reset_mid_scan");
      model_clear();
      @(negedge clk);
      rst_n = 1;
      #1;
      check_cleared("reset_mid_release");
      send(1, 7'd70, 24'd500);
      total++;
      if (voice_active !== 4'b0001 || voice_note[6:0] !== 7'd70)
         $display("FAIL after_reset_v0: got %b/%0d want 0001/70",
                  voice_active, voice_note[6:0]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_steal();
      test_note_off();
      test_retrigger();
      test_reset_mid_scan();
      total++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_left: got %0d want 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic successor to the single-voice note path between the MIDI processor and the synthesizer. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots. When all slots are busy it steals the oldest voice. Per-voice active/note/tick outputs feed a multi-voice synthesizer, and an LED vector shows voice activity.

Parameters:
NUM_VOICES, 4, number of voice slots (2..16)
TICK_WIDTH, 24, width of the note sample-tick period value
AGE_WIDTH, 8, width of each per-voice saturating age counter

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
EVT_VALID  in  1  event present; payload stable while EVT_VALID && !EVT_READY
EVT_READY  out  1  allocator idle, can accept an event
EVT_NOTE_ON  in  1  1 = note-on, 0 = note-off
EVT_NOTE  in  7  MIDI note number
EVT_TICKS  in  TICK_WIDTH  sample-tick period for note-on
VOICE_ACTIVE  out  NUM_VOICES  bit i = voice i sounding
VOICE_NOTE  out  NUM_VOICES*7  voice i note at [7i+6:7i]
VOICE_TICKS  out  NUM_VOICES*TICK_WIDTH  voice i ticks at [TW*i+TW-1:TW*i]
STEAL_PULSE  out  1  one-cycle pulse when a note-on steals an active voice
LED  out  8  LED[i] = VOICE_ACTIVE[i] for i < min(8,NUM_VOICES), else 0

Behaviour:
- Reset: all outputs 0 except EVT_READY = 1. All age counters 0. FSM = IDLE. Reset is asynchronous; any latched event is dropped.
- FSM IDLE -> SCAN -> COMMIT -> IDLE. EVT_READY = 1 only in IDLE (registered).
- Accept edge E0 (IDLE, EVT_VALID=1): latch EVT_NOTE_ON, EVT_NOTE and EVT_TICKS. Go to SCAN with index 0. Clear the search results.
- SCAN: edges E1..EN each examine one voice, index 0..N-1. Record three results:
  - match: lowest index with active && note == latched note.
  - free: lowest inactive index.
  - oldest: active voice with the largest age; ties go to the lowest index.
  - After index N-1, go to COMMIT.
- COMMIT, edge E(N+1): apply the update, go to IDLE. Every output register (VOICE_*, LED, STEAL_PULSE) changes only on this edge. EVT_READY is low for exactly N+1 cycles after acceptance.
- Note-on with EVT_TICKS == 0 is treated as a note-off for that note.
- Note-on priority:
  - match: retrigger the same voice. Ticks updated, age = 0.
  - else free: write note/ticks, set active, age = 0.
  - else steal oldest: overwrite note/ticks, age = 0, STEAL_PULSE = 1 for the cycle after E(N+1).
  - On any note-on commit, every other active voice's age increments, saturating at 2^AGE_WIDTH-1.
- Note-off with a match: that voice's active, note, ticks and age all go to 0. Other ages unchanged.
- Note-off without a match: no output change, no pulse.
- STEAL_PULSE returns to 0 on the next edge. It never stays high for 2 cycles.
- Duplicate note-on for a held note never occupies two voices.
- EVT_VALID while EVT_READY = 0 is ignored. The source must hold the event until the handshake.

Test Plan:
- RESET_N low mid-run, then high -> all VOICE_*, LED and STEAL_PULSE = 0, EVT_READY = 1 on release.
- N=4: note-ons 60, 62, 64, 65 with ticks 1000..1003, back-to-back -> voices 0..3 in order, VOICE_ACTIVE = 4'b1111, LED = 8'h0F. Each event has EVT_READY low for 5 cycles, and outputs change 5 edges after acceptance.
- Then note-on 67, ticks 2000 -> voice 0 (age 3, oldest) becomes note 67 / 2000. STEAL_PULSE high exactly one cycle. Voices 1..3 unchanged.
- Note-off 62 -> voice 1 inactive, note/ticks 0, LED = 8'h0D. Next note-on 69 -> voice 1, no STEAL_PULSE.
- Note-on 64 with ticks 3000 while held -> voice 2 ticks = 3000, age 0, no other voice changes. Note-off for unheld 50 -> no change. Note-on 65 with ticks 0 -> voice 3 released.
- RESET_N pulsed low during SCAN of a note-on -> event dropped, all voices cleared, next event after release allocates voice 0.
